// File: rtl/device_irq_arbiter.sv
// Four-source round-robin IRQ arbiter with a REQ/WAIT_ACK/DONE handshake toward the CPU.
// Optional WAIT_ACK timeout is enabled by defining DEVICE_IRQ_ARBITER_TIMEOUT_EN.
module device_irq_arbiter #(
    parameter int P_TIMEOUT_CYCLES = 1024
) (
    input  logic       iCLOCK,
    input  logic       inRESET,
    input  logic       iRESET_SYNC,
    input  logic [3:0] iDEV_IRQ_REQ,
    input  logic [3:0] iDEV_IRQ_MASK,
    output logic [3:0] oDEV_IRQ_BUSY,
    output logic [3:0] oDEV_IRQ_ACK,
    output logic       oIRQ_VALID,
    input  logic       iIRQ_BUSY,
    output logic [1:0] oIRQ_NUM,
    input  logic       iIRQ_ACK,
    output logic       oTIMEOUT
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_ACK, S_DONE} state_t;

    state_t     state_q, state_d;
    logic [1:0] b_num_q, b_num_d;
    logic [1:0] b_last_q, b_last_d;
    logic       timeout_q, timeout_d;
    logic [3:0] pend;
    logic [1:0] winner;
    logic [1:0] idx;
    logic       found;
    logic       expire;

    // First pending source after the last grant, wrapping mod 4.
    always_comb begin
        pend   = iDEV_IRQ_REQ & ~iDEV_IRQ_MASK;
        winner = b_last_q;
        found  = 1'b0;
        idx    = 2'd0;
        for (int i = 1; i <= 4; i++) begin
            idx = b_last_q + 2'(i);
            if (!found && pend[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

`ifdef DEVICE_IRQ_ARBITER_TIMEOUT_EN
    localparam int CW = ($clog2(P_TIMEOUT_CYCLES) > 0) ? $clog2(P_TIMEOUT_CYCLES) : 1;
    logic [CW-1:0] cnt_q, cnt_d;

    // Zero outside WAIT_ACK, so it is clear on every entry.
    always_comb begin
        cnt_d = '0;
        if (state_q == S_WAIT_ACK) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET)         cnt_q <= '0;
        else if (iRESET_SYNC) cnt_q <= '0;
        else                  cnt_q <= cnt_d;
    end

    assign expire = (state_q == S_WAIT_ACK) && (cnt_q == CW'(P_TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^P_TIMEOUT_CYCLES;
    assign expire = 1'b0;
`endif

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            state_q   <= S_IDLE;
            b_num_q   <= 2'd0;
            b_last_q  <= 2'd3;
            timeout_q <= 1'b0;
        end else if (iRESET_SYNC) begin
            state_q   <= S_IDLE;
            b_num_q   <= 2'd0;
            b_last_q  <= 2'd3;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            b_num_q   <= b_num_d;
            b_last_q  <= b_last_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        b_num_d   = b_num_q;
        b_last_d  = b_last_q;
        timeout_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (|pend) begin
                    b_num_d = winner;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (!iIRQ_BUSY) state_d = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                // A CPU ack arriving on the expiry cycle still completes normally.
                if (iIRQ_ACK) begin
                    state_d = S_DONE;
                end else if (expire) begin
                    state_d   = S_IDLE;
                    b_last_d  = b_num_q;
                    timeout_d = 1'b1;
                end
            end
            S_DONE: begin
                b_last_d = b_num_q;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        oIRQ_VALID    = (state_q == S_REQ);
        oDEV_IRQ_BUSY = (state_q == S_IDLE) ? 4'b0000 : 4'b1111;
        oDEV_IRQ_ACK  = (state_q == S_DONE) ? (4'b0001 << b_num_q) : 4'b0000;
        oIRQ_NUM      = b_num_q;
        oTIMEOUT      = timeout_q;
    end

endmodule
